// File: rtl/fpu_clk_rst_seq_if.sv
// Handshake and status bundle between the test/power controller and the
// FPU cluster clock/reset sequencer.
interface fpu_clk_rst_seq_if;
  logic       wmr_req;
  logic       dbg_req;
  logic       stop_req;
  logic       cluster_cken;
  logic       grst_l;
  logic       gdbginit_l;
  logic       stop_ack;
  logic       rst_done;
  logic [2:0] seq_state;

  modport master (
    output wmr_req, dbg_req, stop_req,
    input  cluster_cken, grst_l, gdbginit_l, stop_ack, rst_done, seq_state
  );

  modport slave (
    input  wmr_req, dbg_req, stop_req,
    output cluster_cken, grst_l, gdbginit_l, stop_ack, rst_done, seq_state
  );
endinterface

// File: rtl/fpu_clk_rst_seq.sv
// Clock/reset sequencer for one FPU cluster header: power-on and warm reset,
// debug-init pulses, and cluster clock stop/restart with request/ack.
module fpu_clk_rst_seq #(
  parameter int CKEN_DLY = 4,
  parameter int GRST_DLY = 8,
  parameter int DBG_LEN  = 6,
  parameter int STOP_LAT = 2,
  parameter int CNT_W    = 8
) (
  input logic               gclk,
  input logic               arst_l,
  fpu_clk_rst_seq_if.slave  sif
);

  typedef enum logic [2:0] {
    CKEN_WAIT  = 3'd0,
    GRST_WAIT  = 3'd1,
    RUN        = 3'd2,
    DBG        = 3'd3,
    STOP_DRAIN = 3'd4,
    STOPPED    = 3'd5
  } state_e;

  // Counter holds the number of edges already spent in the state, so the
  // transition fires on the edge where it equals length-1.
  localparam logic [CNT_W-1:0] CKEN_LAST = CNT_W'(CKEN_DLY - 1);
  localparam logic [CNT_W-1:0] GRST_LAST = CNT_W'(GRST_DLY - 1);
  localparam logic [CNT_W-1:0] DBG_LAST  = CNT_W'(DBG_LEN - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_LAT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cken_q, cken_d;
  logic             grst_q, grst_d;
  logic             dbgi_q, dbgi_d;
  logic             ack_q, ack_d;
  logic             done_q, done_d;
  logic             warm;

  always_ff @(posedge gclk or negedge arst_l) begin
    if (!arst_l) begin
      state_q <= CKEN_WAIT;
      cnt_q   <= '0;
      cken_q  <= 1'b0;
      grst_q  <= 1'b0;
      dbgi_q  <= 1'b0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cken_q  <= cken_d;
      grst_q  <= grst_d;
      dbgi_q  <= dbgi_d;
      ack_q   <= ack_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    cken_d  = cken_q;
    grst_d  = grst_q;
    dbgi_d  = dbgi_q;
    ack_d   = ack_q;
    done_d  = done_q;
    warm    = 1'b0;

    unique case (state_q)
      CKEN_WAIT: begin
        if (cnt_q == CKEN_LAST) begin
          cken_d  = 1'b1;
          cnt_d   = '0;
          state_d = GRST_WAIT;
        end
      end
      GRST_WAIT: begin
        if (cnt_q == GRST_LAST) begin
          grst_d  = 1'b1;
          dbgi_d  = 1'b1;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cnt_d = '0;
        if (sif.wmr_req) begin
          warm = 1'b1;
        end else if (sif.dbg_req) begin
          dbgi_d  = 1'b0;
          state_d = DBG;
        end else if (sif.stop_req) begin
          cken_d  = 1'b0;
          state_d = STOP_DRAIN;
        end
      end
      DBG: begin
        // Repeated dbg_req is not looked at: the pulse length is fixed.
        if (sif.wmr_req) begin
          warm = 1'b1;
        end else if (cnt_q == DBG_LAST) begin
          dbgi_d  = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      STOP_DRAIN: begin
        // Drain always completes, even if stop_req drops meanwhile.
        if (sif.wmr_req) begin
          warm = 1'b1;
        end else if (cnt_q == STOP_LAST) begin
          ack_d   = 1'b1;
          cnt_d   = '0;
          state_d = STOPPED;
        end
      end
      STOPPED: begin
        cnt_d = '0;
        if (sif.wmr_req) begin
          warm = 1'b1;
        end else if (!sif.stop_req) begin
          cken_d  = 1'b1;
          ack_d   = 1'b0;
          state_d = RUN;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = CKEN_WAIT;
      end
    endcase

    // Warm reset keeps the cluster clock running so the header sees grst_l.
    if (warm) begin
      cken_d  = 1'b1;
      ack_d   = 1'b0;
      grst_d  = 1'b0;
      dbgi_d  = 1'b0;
      done_d  = 1'b0;
      cnt_d   = '0;
      state_d = GRST_WAIT;
    end
  end

  assign sif.cluster_cken = cken_q;
  assign sif.grst_l       = grst_q;
  assign sif.gdbginit_l   = dbgi_q;
  assign sif.stop_ack     = ack_q;
  assign sif.rst_done     = done_q;
  assign sif.seq_state    = state_q;

endmodule

// File: tb/tb_fpu_clk_rst_seq.sv
// Directed bench: default-parameter instance plus a short-delay instance
// (CKEN_DLY=1, GRST_DLY=1) used for the async-reset-in-DBG case.
module tb_fpu_clk_rst_seq;
  logic gclk;
  logic arst_a, arst_b;
  int   n_chk, n_fail;

  fpu_clk_rst_seq_if a_if ();
  fpu_clk_rst_seq_if b_if ();

  fpu_clk_rst_seq u_dut_a (
    .gclk   (gclk),
    .arst_l (arst_a),
    .sif    (a_if)
  );

  fpu_clk_rst_seq #(.CKEN_DLY(1), .GRST_DLY(1)) u_dut_b (
    .gclk   (gclk),
    .arst_l (arst_b),
    .sif    (b_if)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge gclk);
      #1;
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    arst_a = 1'b0; arst_b = 1'b0;
    a_if.wmr_req = 1'b0; a_if.dbg_req = 1'b0; a_if.stop_req = 1'b0;
    b_if.wmr_req = 1'b0; b_if.dbg_req = 1'b0; b_if.stop_req = 1'b0;

    // Reset values
    #2;
    check("rst_cken",  a_if.cluster_cken, 0);
    check("rst_grst",  a_if.grst_l,       0);
    check("rst_dbgi",  a_if.gdbginit_l,   0);
    check("rst_ack",   a_if.stop_ack,     0);
    check("rst_done",  a_if.rst_done,     0);
    check("rst_state", a_if.seq_state,    0);

    // Release both resets between edges; next posedge is edge 1
    tick();
    arst_a = 1'b1; arst_b = 1'b1;

    tick(); // edge 1
    check("po_e1_cken_a",  a_if.cluster_cken, 0);
    check("po_e1_cken_b",  b_if.cluster_cken, 1);
    check("po_e1_grst_b",  b_if.grst_l,       0);
    check("po_e1_state_b", b_if.seq_state,    1);
    tick(); // edge 2
    check("po_e2_grst_b",  b_if.grst_l,       1);
    check("po_e2_done_b",  b_if.rst_done,     1);
    check("po_e2_state_b", b_if.seq_state,    2);
    tick(); // edge 3
    check("po_e3_cken",  a_if.cluster_cken, 0);
    check("po_e3_state", a_if.seq_state,    0);
    tick(); // edge 4
    check("po_e4_cken",  a_if.cluster_cken, 1);
    check("po_e4_state", a_if.seq_state,    1);
    check("po_e4_grst",  a_if.grst_l,       0);
    tick(7); // edge 11
    check("po_e11_grst", a_if.grst_l,   0);
    check("po_e11_done", a_if.rst_done, 0);
    tick(); // edge 12
    check("po_e12_grst",  a_if.grst_l,     1);
    check("po_e12_dbgi",  a_if.gdbginit_l, 1);
    check("po_e12_done",  a_if.rst_done,   1);
    check("po_e12_state", a_if.seq_state,  2);

    // Debug pulse with a second request at k+2
    a_if.dbg_req = 1'b1;
    tick(); // k
    check("dbg_k_dbgi",  a_if.gdbginit_l, 0);
    check("dbg_k_state", a_if.seq_state,  3);
    a_if.dbg_req = 1'b0;
    tick(); // k+1
    a_if.dbg_req = 1'b1;
    tick(); // k+2
    a_if.dbg_req = 1'b0;
    tick(3); // k+5
    check("dbg_k5_dbgi", a_if.gdbginit_l,   0);
    check("dbg_k5_cken", a_if.cluster_cken, 1);
    check("dbg_k5_grst", a_if.grst_l,       1);
    tick(); // k+6
    check("dbg_k6_dbgi",  a_if.gdbginit_l, 1);
    check("dbg_k6_state", a_if.seq_state,  2);
    tick();
    check("dbg_k7_dbgi", a_if.gdbginit_l, 1);

    // Stop / restart
    a_if.stop_req = 1'b1;
    tick(); // k
    check("stop_k_cken",  a_if.cluster_cken, 0);
    check("stop_k_ack",   a_if.stop_ack,     0);
    check("stop_k_state", a_if.seq_state,    4);
    tick(); // k+1
    check("stop_k1_ack", a_if.stop_ack, 0);
    tick(); // k+2
    check("stop_k2_ack",   a_if.stop_ack,  1);
    check("stop_k2_state", a_if.seq_state, 5);
    tick(3);
    check("stop_hold_ack",  a_if.stop_ack,     1);
    check("stop_hold_cken", a_if.cluster_cken, 0);
    a_if.stop_req = 1'b0;
    tick(); // j
    check("restart_cken",  a_if.cluster_cken, 1);
    check("restart_ack",   a_if.stop_ack,     0);
    check("restart_state", a_if.seq_state,    2);

    // Warm reset while STOPPED
    a_if.stop_req = 1'b1;
    tick(3);
    check("wmr_pre_state", a_if.seq_state, 5);
    a_if.wmr_req = 1'b1; a_if.stop_req = 1'b0;
    tick(); // k
    a_if.wmr_req = 1'b0;
    check("wmr_k_cken",  a_if.cluster_cken, 1);
    check("wmr_k_ack",   a_if.stop_ack,     0);
    check("wmr_k_grst",  a_if.grst_l,       0);
    check("wmr_k_done",  a_if.rst_done,     0);
    check("wmr_k_dbgi",  a_if.gdbginit_l,   0);
    check("wmr_k_state", a_if.seq_state,    1);
    tick(7); // k+7
    check("wmr_k7_grst", a_if.grst_l, 0);
    tick(); // k+8
    check("wmr_k8_grst",  a_if.grst_l,    1);
    check("wmr_k8_done",  a_if.rst_done,  1);
    check("wmr_k8_state", a_if.seq_state, 2);

    // Priority: all three requests in one RUN cycle
    a_if.wmr_req = 1'b1; a_if.dbg_req = 1'b1; a_if.stop_req = 1'b1;
    tick();
    a_if.wmr_req = 1'b0; a_if.dbg_req = 1'b0;
    check("pri_state", a_if.seq_state,    1);
    check("pri_dbgi",  a_if.gdbginit_l,   0);
    check("pri_cken",  a_if.cluster_cken, 1);
    tick(7);
    check("pri_k7_state", a_if.seq_state, 1);
    check("pri_k7_ack",   a_if.stop_ack,  0);
    check("pri_k7_dbgi",  a_if.gdbginit_l, 0);
    tick(); // k+8
    check("pri_k8_grst",  a_if.grst_l,     1);
    check("pri_k8_dbgi",  a_if.gdbginit_l, 1);
    check("pri_k8_state", a_if.seq_state,  2);
    tick(); // stop_req resampled in RUN
    check("pri_stop_state", a_if.seq_state,    4);
    check("pri_stop_cken",  a_if.cluster_cken, 0);
    // Drop stop_req mid-drain: drain completes, then a 1-cycle ack
    a_if.stop_req = 1'b0;
    tick();
    check("drain_fall_ack0", a_if.stop_ack, 0);
    tick();
    check("drain_fall_ack1",  a_if.stop_ack,  1);
    check("drain_fall_state", a_if.seq_state, 5);
    tick();
    check("drain_fall_ack2",  a_if.stop_ack,     0);
    check("drain_fall_cken",  a_if.cluster_cken, 1);
    check("drain_fall_run",   a_if.seq_state,    2);

    // Async reset mid-DBG on the short-delay instance
    b_if.dbg_req = 1'b1;
    tick();
    b_if.dbg_req = 1'b0;
    check("b_dbg_state", b_if.seq_state,  3);
    check("b_dbg_dbgi",  b_if.gdbginit_l, 0);
    tick();
    arst_b = 1'b0;
    #1;
    check("arst_cken",  b_if.cluster_cken, 0);
    check("arst_grst",  b_if.grst_l,       0);
    check("arst_dbgi",  b_if.gdbginit_l,   0);
    check("arst_done",  b_if.rst_done,     0);
    check("arst_state", b_if.seq_state,    0);
    tick();
    check("arst_hold_cken", b_if.cluster_cken, 0);
    arst_b = 1'b1;
    tick(); // edge 1
    check("arst_e1_cken", b_if.cluster_cken, 1);
    check("arst_e1_grst", b_if.grst_l,       0);
    tick(); // edge 2
    check("arst_e2_grst",  b_if.grst_l,    1);
    check("arst_e2_state", b_if.seq_state, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
